rcv_unstuff_shift: RTL and testbench



---
 rtl/rcv_unstuff_shift_pkg.sv | 16 +
 rtl/rcv_unstuff_shift_if.sv | 27 ++
 rtl/rcv_unstuff_shift_ones.sv | 38 +++
 rtl/rcv_unstuff_shift.sv | 93 +++++++++
 tb/tb_rcv_unstuff_shift.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/rcv_unstuff_shift_pkg.sv
// rcv_pkg: shared types and constants for the USB receive unstuff/shift path.
//   unstuff_state_t : IDLE / SHIFT / ERR state encoding
//   USB_MAX_ONES    : consecutive 1s that force a stuffed 0
//   USB_BYTE_W      : receive byte width
package rcv_pkg;

  localparam int USB_MAX_ONES = 6;
  localparam int USB_BYTE_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ERR   = 2'd2
  } unstuff_state_t;

endpackage

// File: rtl/rcv_unstuff_shift_if.sv
// rcv_unstuff_shift_if: bit-in / byte-out bundle between the NRZI decoder
// side and the receive byte FSM side.
//   master : drives d_prim, bit_strobe, packet_done; observes the byte outputs
//   slave  : the unstuff/shift stage itself
interface rcv_unstuff_shift_if #(
  parameter int DATA_W = 8
);

  logic              d_prim;
  logic              bit_strobe;
  logic              packet_done;
  logic [DATA_W-1:0] rx_byte;
  logic              byte_valid;
  logic              stuff_err;
  logic              partial_err;

  modport master (
    output d_prim, bit_strobe, packet_done,
    input  rx_byte, byte_valid, stuff_err, partial_err
  );

  modport slave (
    input  d_prim, bit_strobe, packet_done,
    output rx_byte, byte_valid, stuff_err, partial_err
  );

endinterface

// File: rtl/rcv_unstuff_shift_ones.sv
// rcv_ones_counter: counts consecutive 1 data bits and flags when the next
// bit on the wire must be a stuffed 0.
//   clk, rst  : clock, async active-high reset
//   clear     : return count to 0 (packet end or stuff bit consumed)
//   data_en   : a data bit is being accepted this cycle
//   d         : value of that data bit
//   stuff_due : count has reached MAX_ONES
module rcv_ones_counter
  import rcv_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic data_en,
  input  logic d,
  output logic stuff_due
);

  localparam int CW = $clog2(MAX_ONES + 1);

  logic [CW-1:0] ones_cnt;

  // Not cleared on byte completion: a run of 1s may straddle two bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (clear) begin
      ones_cnt <= '0;
    end else if (data_en) begin
      ones_cnt <= d ? ones_cnt + CW'(1) : '0;
    end
  end

  assign stuff_due = (ones_cnt == CW'(MAX_ONES));

endmodule

// File: rtl/rcv_unstuff_shift.sv
// rcv_unstuff_shift: removes USB stuff bits from the decoded stream and packs
// the surviving bits LSB-first into bytes.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of rcv_unstuff_shift_if
//              in : d_prim, bit_strobe, packet_done
//              out: rx_byte, byte_valid (pulse), stuff_err (sticky),
//                   partial_err (pulse)
module rcv_unstuff_shift
  import rcv_pkg::*;
#(
  parameter int DATA_W   = USB_BYTE_W,
  parameter int MAX_ONES = USB_MAX_ONES
) (
  input  logic                clk,
  input  logic                rst,
  rcv_unstuff_shift_if.slave  bus
);

  localparam int              BW   = $clog2(DATA_W);
  localparam logic [BW-1:0]   LAST = BW'(DATA_W - 1);

  unstuff_state_t    state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] rx_byte_q;
  logic              byte_valid_q;
  logic              stuff_err_q;
  logic              partial_err_q;

  logic stuff_due;
  logic take;
  logic data_en;
  logic stuff_bit;
  logic violation;

  // packet_done has priority over a coincident strobe; ERR ignores strobes.
  assign take      = bus.bit_strobe && !bus.packet_done && (state != ERR);
  assign data_en   = take && !stuff_due;
  assign stuff_bit = take &&  stuff_due && !bus.d_prim;
  assign violation = take &&  stuff_due &&  bus.d_prim;

  rcv_ones_counter #(
    .MAX_ONES (MAX_ONES)
  ) u_ones (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.packet_done || stuff_bit),
    .data_en   (data_en),
    .d         (bus.d_prim),
    .stuff_due (stuff_due)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      sr            <= '0;
      rx_byte_q     <= '0;
      byte_valid_q  <= 1'b0;
      stuff_err_q   <= 1'b0;
      partial_err_q <= 1'b0;
    end else begin
      byte_valid_q  <= 1'b0;
      partial_err_q <= 1'b0;
      if (bus.packet_done) begin
        partial_err_q <= (state == SHIFT) && (bit_cnt != '0);
        bit_cnt       <= '0;
        sr            <= '0;
        stuff_err_q   <= 1'b0;
        state         <= IDLE;
      end else if (violation) begin
        stuff_err_q <= 1'b1;
        state       <= ERR;
      end else if (data_en) begin
        sr    <= {bus.d_prim, sr[DATA_W-1:1]};
        state <= SHIFT;
        if (bit_cnt == LAST) begin
          rx_byte_q    <= {bus.d_prim, sr[DATA_W-1:1]};
          byte_valid_q <= 1'b1;
          bit_cnt      <= '0;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  assign bus.rx_byte     = rx_byte_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.stuff_err   = stuff_err_q;
  assign bus.partial_err = partial_err_q;

endmodule

// File: tb/tb_rcv_unstuff_shift.sv
// Directed bench for rcv_unstuff_shift: bit vectors are given with element i
// being the i-th bit on the wire; expected bytes are hand-computed.
module tb_rcv_unstuff_shift;
  import rcv_pkg::*;

  logic clk;
  logic rst;

  rcv_unstuff_shift_if #(.DATA_W(8)) bus ();

  rcv_unstuff_shift #(
    .DATA_W   (8),
    .MAX_ONES (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at a falling edge, return at the next falling
  // edge (outputs of that cycle visible), then release the strobes.
  task automatic step(input logic s, input logic b, input logic pd);
    bus.bit_strobe  = s;
    bus.d_prim      = b;
    bus.packet_done = pd;
    @(negedge clk);
    bus.bit_strobe  = 1'b0;
    bus.d_prim      = 1'b0;
    bus.packet_done = 1'b0;
  endtask

  // Back-to-back strobes of n bits; records every byte_valid pulse.
  int          vcount;
  int          first_idx, last_idx;
  logic [7:0]  first_byte, last_byte;

  task automatic send_bits(input logic [15:0] bits, input int n);
    vcount     = 0;
    first_idx  = -1;
    last_idx   = -1;
    first_byte = '0;
    last_byte  = '0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[i], 1'b0);
      if (bus.byte_valid) begin
        if (vcount == 0) begin
          first_idx  = i;
          first_byte = bus.rx_byte;
        end
        vcount++;
        last_idx  = i;
        last_byte = bus.rx_byte;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.d_prim      = 1'b0;
    bus.bit_strobe  = 1'b0;
    bus.packet_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_byte", 32'(bus.rx_byte), 32'h0);
    chk("rst_byte_valid", 32'(bus.byte_valid), 32'h0);
    chk("rst_stuff_err", 32'(bus.stuff_err), 32'h0);
    chk("rst_partial_err", 32'(bus.partial_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 0x3C, no stuffing
    send_bits(16'h003C, 8);
    chk("b3c_count", 32'(vcount), 32'd1);
    chk("b3c_idx", 32'(first_idx), 32'd7);
    chk("b3c_byte", 32'(first_byte), 32'h3C);
    chk("b3c_stuff_err", 32'(bus.stuff_err), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("b3c_valid_drop", 32'(bus.byte_valid), 32'h0);
    chk("b3c_rx_hold", 32'(bus.rx_byte), 32'h3C);
    step(1'b0, 1'b0, 1'b1);
    chk("b3c_no_partial", 32'(bus.partial_err), 32'h0);

    // six 1s, stuffed 0, two 1s -> 0xFF on the 9th strobe
    send_bits(16'h01BF, 9);
    chk("ff_count", 32'(vcount), 32'd1);
    chk("ff_idx", 32'(first_idx), 32'd8);
    chk("ff_byte", 32'(first_byte), 32'hFF);
    chk("ff_stuff_err", 32'(bus.stuff_err), 32'h0);
    step(1'b0, 1'b0, 1'b1);

    // seven 1s -> violation on the 7th
    send_bits(16'h003F, 6);
    chk("viol_pre", 32'(bus.stuff_err), 32'h0);
    send_bits(16'h0001, 1);
    chk("viol_set", 32'(bus.stuff_err), 32'h1);
    send_bits(16'h0000, 8);
    chk("viol_no_valid", 32'(vcount), 32'd0);
    chk("viol_sticky", 32'(bus.stuff_err), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    chk("viol_clr", 32'(bus.stuff_err), 32'h0);
    chk("viol_no_partial", 32'(bus.partial_err), 32'h0);

    // three bits then packet end, then 0xA5
    send_bits(16'h0005, 3);
    step(1'b0, 1'b0, 1'b1);
    chk("part_pulse", 32'(bus.partial_err), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("part_one_cycle", 32'(bus.partial_err), 32'h0);
    send_bits(16'h00A5, 8);
    chk("a5_count", 32'(vcount), 32'd1);
    chk("a5_byte", 32'(first_byte), 32'hA5);

    // 8th bit coincident with packet_done
    send_bits(16'h0000, 7);
    step(1'b1, 1'b0, 1'b1);
    chk("pd8_no_valid", 32'(bus.byte_valid), 32'h0);
    chk("pd8_rx_hold", 32'(bus.rx_byte), 32'hA5);
    chk("pd8_partial", 32'(bus.partial_err), 32'h1);

    // reset after five 1s, then 0x81 must not see a stuff bit
    send_bits(16'h001F, 5);
    #2 rst = 1'b1;
    #2;
    chk("mid_rst_rx", 32'(bus.rx_byte), 32'h0);
    chk("mid_rst_flags", 32'({bus.byte_valid, bus.stuff_err, bus.partial_err}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_bits(16'h0081, 8);
    chk("b81_count", 32'(vcount), 32'd1);
    chk("b81_byte", 32'(first_byte), 32'h81);
    chk("b81_stuff_err", 32'(bus.stuff_err), 32'h0);
    step(1'b0, 1'b0, 1'b1);

    // full-rate 0x55 then 0xAA
    send_bits(16'hAA55, 16);
    chk("b2b_count", 32'(vcount), 32'd2);
    chk("b2b_first_idx", 32'(first_idx), 32'd7);
    chk("b2b_first", 32'(first_byte), 32'h55);
    chk("b2b_last_idx", 32'(last_idx), 32'd15);
    chk("b2b_last", 32'(last_byte), 32'hAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
